gfx_boot_fetch: RTL and testbench
=================================

# gfx_boot_fetch

AXI-Lite read initiator that copies a contiguous block of 32-bit words from an AXI-Lite responder (normally the graphics boot ROM) into a valid/ready word stream. It sits between the boot ROM and the consumer that loads the shader/command core at bring-up. It issues one read at a time, tolerates responders that complete R before AR, and stops on the first error response.

## Interface
Parameters:
- WORDS, 128: number of words fetched per run; at least 1; need not be a power of two.
- BASE, 0: byte address of word 0; word-aligned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle run request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the cycle the run ends.
- done  out  1  one-cycle pulse when a run ends, on success or error.
- err  out  1  set when a run ends on a non-OKAY rresp; cleared by the next accepted start.
- axim  if_axil.m  read channels only; awvalid=0, wvalid=0, bready=1 at all times.
- out_data  out  word  fetched word.
- out_index  out  IDX_BITS  word index, 0..WORDS-1.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.

## Operation
- Index counter idx counts 0..WORDS-1. araddr = BASE + (idx << SUBWORD_BITS), truncated to the araddr width. araddr holds steady while arvalid is high.
- States:
  - IDLE: if start, then idx←0, err←0, go to REQ.
  - REQ: assert arvalid until the AR handshake completes, then drop it. Assert rready until the R handshake completes, then drop it. Flags ar_ok and r_ok record completion. The two handshakes complete in either order or in the same cycle. An R handshake before the AR handshake is legal.
    - Both flags set with rresp == OKAY: latch rdata, go to PUSH.
    - Both flags set with rresp ≠ OKAY: err←1, pulse done, go to IDLE.
  - PUSH: out_valid=1 holding the latched word and idx, until out_ready.
    - On acceptance with idx == WORDS-1: pulse done, go to IDLE.
    - Otherwise: idx←idx+1, go to REQ.
- rresp is captured in the R-handshake cycle. rdata is ignored outside that cycle.
- start outside IDLE is ignored.
- Reset mid-run aborts immediately: all outputs return to reset values and no done is generated. A responder transaction in flight is abandoned; the responder must also be reset.

## Timing
- Reset values: arvalid=0, rready=0, araddr=BASE, out_valid=0, out_data=0, out_index=0, busy=0, done=0, err=0.
- Start seen at edge t: REQ is active during t+1, with arvalid=rready=1 and busy=1.
- Zero-wait responder (arready and rvalid in the first REQ cycle): out_valid rises one cycle later. Steady-state throughput is one word per 2 cycles when out_ready is held high.
- done rises in the cycle after the final out handshake or the error R handshake. busy falls in that same cycle.
- At most one read is outstanding. arvalid and rready are never reasserted within one REQ visit.

## Configuration
- GFX_BOOT_FETCH_AUTOSTART_EN defined: the first clock edge after rst_n deasserts acts as an accepted start. External start remains functional afterwards.
- Not defined: runs begin only on start.

## Structure
- gfx package:
  - word and SUBWORD_BITS (existing).
  - New enum gfx_boot_fetch_state (IDLE, REQ, PUSH).
  - AXI response constant AXI_RESP_OKAY = 2'b00.
- IDX_BITS = $clog2(WORDS), minimum 1, is a local parameter.
- No sub-module: the FSM, counter and AXI tie-offs stay in one module.

## Test plan
- Zero-wait responder, WORDS=4, BASE=0x100, memory 0xA0..0xA3, out_ready=1:
  - araddr sequence 0x100, 0x104, 0x108, 0x10C.
  - out stream (0,0xA0)..(3,0xA3).
  - Single done; err=0.
- Responder that returns R before AR (boot-ROM style, arready after rready):
  - All WORDS words delivered in order.
  - No duplicate AR.
  - arvalid is never held past its handshake.
- rresp=SLVERR on word 2 of 4:
  - Words 0–1 delivered.
  - done with err=1.
  - No further AR; busy=0.
- Backpressure: out_ready low for 5 cycles during word 1:
  - out_data/out_index stable.
  - No AR issued until acceptance.
- start pulsed while busy: ignored, no second run. Then start after done: err cleared and the run repeats.
- rst_n asserted in REQ: all outputs at reset values the same cycle. With GFX_BOOT_FETCH_AUTOSTART_EN, a run starts one edge after release.

Source files
------------

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics types: word, sub-word shift, AXI response codes, boot fetch states
package gfx_pkg;

  typedef logic [31:0] word;
  localparam int SUBWORD_BITS = 2;

  localparam int AXIL_ADDR_W = 32;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PUSH
  } gfx_boot_fetch_state;

endpackage

// File: rtl/if_axil.sv
// rtl/if_axil.sv - AXI-Lite bus bundle with initiator (m) and responder (s) views
interface if_axil;

  logic [gfx_pkg::AXIL_ADDR_W-1:0] awaddr;
  logic                            awvalid;
  logic                            awready;
  logic [31:0]                     wdata;
  logic [3:0]                      wstrb;
  logic                            wvalid;
  logic                            wready;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;
  logic [gfx_pkg::AXIL_ADDR_W-1:0] araddr;
  logic                            arvalid;
  logic                            arready;
  logic [31:0]                     rdata;
  logic [1:0]                      rresp;
  logic                            rvalid;
  logic                            rready;

  modport m (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport s (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/gfx_boot_fetch.sv
// rtl/gfx_boot_fetch.sv - copies WORDS words from an AXI-Lite responder into a valid/ready stream
// Optional: GFX_BOOT_FETCH_AUTOSTART_EN starts a run on the first edge after reset release.
module gfx_boot_fetch
  import gfx_pkg::*;
#(
  parameter int          WORDS    = 128,
  parameter logic [31:0] BASE     = 32'h0,
  localparam int         IDX_BITS = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  if_axil.m                   axim,
  output word                 out_data,
  output logic [IDX_BITS-1:0] out_index,
  output logic                out_valid,
  input  logic                out_ready
);

  gfx_boot_fetch_state r_state, w_state_nxt;

  logic [IDX_BITS-1:0] r_idx;
  logic                r_ar_ok;
  logic                r_r_ok;
  logic [1:0]          r_rresp;
  word                 r_rdata;
  logic                r_done;
  logic                r_err;

  logic w_start;
  logic w_arvalid;
  logic w_rready;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_ar_all;
  logic w_r_all;
  logic [1:0] w_resp;
  logic w_last;
  logic w_accept;
  logic w_advance;
  logic w_fetch_err;
  logic w_run_end;
  logic w_unused;

`ifdef GFX_BOOT_FETCH_AUTOSTART_EN
  logic r_autostart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_autostart <= 1'b1;
    else        r_autostart <= 1'b0;
  end

  assign w_start = start | r_autostart;
`else
  assign w_start = start;
`endif

  // Each valid drops as soon as its own handshake is recorded, so neither is reissued in one visit.
  assign w_arvalid = (r_state == REQ) & ~r_ar_ok;
  assign w_rready  = (r_state == REQ) & ~r_r_ok;
  assign w_ar_hs   = w_arvalid & axim.arready;
  assign w_r_hs    = w_rready & axim.rvalid;
  assign w_ar_all  = r_ar_ok | w_ar_hs;
  assign w_r_all   = r_r_ok | w_r_hs;
  assign w_resp    = w_r_hs ? axim.rresp : r_rresp;
  assign w_last    = (r_idx == IDX_BITS'(WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_fetch_err = 1'b0;
    w_run_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_ar_all && w_r_all) begin
          if (w_resp == AXI_RESP_OKAY) begin
            w_state_nxt = PUSH;
          end else begin
            w_fetch_err = 1'b1;
            w_run_end   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      PUSH: begin
        if (out_ready) begin
          if (w_last) begin
            w_run_end   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = REQ;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ar_ok <= 1'b0;
      r_r_ok  <= 1'b0;
      r_rresp <= AXI_RESP_OKAY;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_run_end;

      if (w_accept) begin
        r_idx <= '0;
        r_err <= 1'b0;
      end else if (w_advance) begin
        r_idx <= r_idx + IDX_BITS'(1);
      end
      if (w_fetch_err) r_err <= 1'b1;

      if (r_state == REQ) begin
        if (w_state_nxt != REQ) begin
          r_ar_ok <= 1'b0;
          r_r_ok  <= 1'b0;
        end else begin
          if (w_ar_hs) r_ar_ok <= 1'b1;
          if (w_r_hs)  r_r_ok  <= 1'b1;
        end
      end

      // The captured word doubles as the stream output; it only matters while in PUSH.
      if (w_r_hs) begin
        r_rresp <= axim.rresp;
        r_rdata <= axim.rdata;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign out_valid = (r_state == PUSH);
  assign out_data  = r_rdata;
  assign out_index = r_idx;

  assign axim.araddr  = AXIL_ADDR_W'(BASE) + (AXIL_ADDR_W'(r_idx) << SUBWORD_BITS);
  assign axim.arvalid = w_arvalid;
  assign axim.rready  = w_rready;

  assign axim.awaddr  = '0;
  assign axim.awvalid = 1'b0;
  assign axim.wdata   = '0;
  assign axim.wstrb   = '0;
  assign axim.wvalid  = 1'b0;
  assign axim.bready  = 1'b1;

  assign w_unused = ^{axim.awready, axim.wready, axim.bresp, axim.bvalid};

endmodule

// File: tb/tb_gfx_boot_fetch.sv
// tb/tb_gfx_boot_fetch.sv - randomized scoreboard bench for gfx_boot_fetch
module tb_gfx_boot_fetch;
  import gfx_pkg::*;

  localparam int          WORDS    = 4;
  localparam logic [31:0] BASE     = 32'h100;
  localparam int          IDX_BITS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, done, err, out_valid;
  logic out_ready;
  word  out_data;
  logic [IDX_BITS-1:0] out_index;

  if_axil axi();

  gfx_boot_fetch #(.WORDS(WORDS), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .axim(axi), .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] idx; word data; } out_t;

  int   checks = 0;
  int   errors = 0;
  word  mem [WORDS];
  int   resp_mode;
  int   err_at;
  int   bp_mode;
  bit   bp_used;
  int   done_seen = 0;
  out_t        exp_out[$];
  logic [31:0] exp_addr[$];
  bit          exp_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=unexpected required=none", name);
  endtask

  // Reference: words 0..last are read in order; a failing word ends the run without being streamed.
  task automatic expect_run();
    int last;
    bit has_err;
    has_err = (err_at >= 0) && (err_at < WORDS);
    last = has_err ? err_at : WORDS - 1;
    for (int i = 0; i <= last; i++) begin
      exp_addr.push_back(BASE + 32'(i) * 32'd4);
      if (!(has_err && i == err_at)) exp_out.push_back('{idx: 32'(i), data: mem[i]});
    end
    exp_done.push_back(has_err);
  endtask

  // Responder: mode 0 zero-wait, mode 1 R strictly before AR, mode 2 random delays.
  initial begin
    int cnt, d_ar, d_r, widx;
    bit active, ar_f, r_f;
    logic [31:0] off;
    active = 0; cnt = 0; d_ar = 0; d_r = 0; ar_f = 0; r_f = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; axi.arready = 0; axi.rvalid = 0;
        continue;
      end
      if (!active && (axi.arvalid || axi.rready)) begin
        active = 1; cnt = 0; ar_f = 0; r_f = 0;
        case (resp_mode)
          0:       begin d_ar = 0; d_r = 0; end
          1:       begin d_ar = $urandom_range(0, 2); d_r = $urandom_range(0, 2); end
          default: begin d_ar = $urandom_range(0, 3); d_r = $urandom_range(0, 3); end
        endcase
      end
      if (active) begin
        off  = axi.araddr - BASE;
        widx = int'(off[31:2]) % WORDS;
        axi.rvalid  = !r_f && (cnt >= d_r);
        axi.arready = !ar_f && (cnt >= d_ar) && (resp_mode != 1 || r_f);
        axi.rdata   = axi.rvalid ? mem[widx] : $urandom;
        axi.rresp   = axi.rvalid ? ((widx == err_at) ? 2'b10 : 2'b00) : 2'($urandom_range(1, 3));
        #1;
        if (axi.arvalid && axi.arready) begin
          ar_f = 1;
          if (exp_addr.size() == 0) fail_now("ar_extra");
          else check("araddr", axi.araddr, exp_addr.pop_front());
        end
        if (axi.rvalid && axi.rready) r_f = 1;
        if (ar_f && r_f) active = 0;
        cnt++;
      end else begin
        axi.arready = 0;
        axi.rvalid  = 0;
      end
    end
  end

  // Consumer
  initial begin
    int lowcnt;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (lowcnt > 0) begin
        out_ready = 0;
        lowcnt--;
      end else if (bp_mode == 2 && out_valid && out_index == 1 && !bp_used) begin
        bp_used = 1;
        lowcnt = 4;
        out_ready = 0;
      end else begin
        out_ready = (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    logic pv, pr, par_hs, pr_hs, parv;
    word pd;
    logic [IDX_BITS-1:0] pi;
    logic [31:0] paddr;
    out_t e;
    bit ed;
    pv = 0; pr = 0; par_hs = 0; pr_hs = 0; parv = 0; pd = 0; pi = 0; paddr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv = 0; par_hs = 0; pr_hs = 0; parv = 0;
        continue;
      end
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
        check("hold_index", out_index, pi);
      end
      if (par_hs) check("arvalid_drop", axi.arvalid, 0);
      if (pr_hs)  check("rready_drop", axi.rready, 0);
      if (parv && !par_hs) begin
        check("arvalid_hold", axi.arvalid, 1);
        check("araddr_hold", axi.araddr, paddr);
      end
      if (out_valid) check("no_ar_in_push", axi.arvalid, 0);
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) fail_now("out_extra");
        else begin
          e = exp_out.pop_front();
          check("out_index", out_index, e.idx);
          check("out_data", out_data, e.data);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done.size() == 0) fail_now("done_extra");
        else begin
          ed = exp_done.pop_front();
          check("done_err", err, ed);
        end
        check("done_busy", busy, 0);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_index;
      par_hs = axi.arvalid & axi.arready;
      pr_hs  = axi.rready & axi.rvalid;
      parv   = axi.arvalid;
      paddr  = axi.araddr;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_arvalid"}, axi.arvalid, 0);
    check({tag, "_rready"}, axi.rready, 0);
    check({tag, "_araddr"}, axi.araddr, BASE);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_index"}, out_index, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #3;
      if (done) begin got = 1; break; end
    end
    if (!got) fail_now(name);
  endtask

  task automatic drain_checks();
    repeat (3) @(negedge clk);
    #3;
    check("idle_busy", busy, 0);
    check("idle_arvalid", axi.arvalid, 0);
    check("left_out", exp_out.size(), 0);
    check("left_addr", exp_addr.size(), 0);
    check("left_done", exp_done.size(), 0);
  endtask

  task automatic run(input bit chk_lat, input bit extra_start);
    int cyc, n;
    bit got;
    expect_run();
    n = done_seen;
    @(negedge clk);
    start = 1;
    cyc = 0;
    got = 0;
    while (cyc < 500) begin
      @(negedge clk);
      cyc++;
      start = extra_start && (cyc == 3);
      #3;
      if (cyc == 1) begin
        check("start_busy", busy, 1);
        check("start_err_clr", err, 0);
        check("start_arvalid", axi.arvalid, 1);
        check("start_rready", axi.rready, 1);
      end
      if (done) begin got = 1; break; end
    end
    if (!got) fail_now("done_timeout");
    else if (chk_lat) check("latency", cyc, 2 * WORDS + 1);
    drain_checks();
    if (extra_start) begin
      repeat (15) @(negedge clk);
      #3;
      check("no_second_run_busy", busy, 0);
      check("no_second_run_done", done_seen, n + 1);
    end
  endtask

  initial begin
    rst_n = 0; start = 0; out_ready = 1;
    resp_mode = 0; err_at = -1; bp_mode = 0; bp_used = 0;
    for (int i = 0; i < WORDS; i++) mem[i] = 32'hA0 + 32'(i);
    #1;
    check_reset_values("rst");
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_bready", axi.bready, 1);
`ifdef GFX_BOOT_FETCH_AUTOSTART_EN
    expect_run();
`endif
    repeat (2) @(negedge clk);
    rst_n = 1;
`ifdef GFX_BOOT_FETCH_AUTOSTART_EN
    wait_done("autostart_timeout");
    drain_checks();
`else
    repeat (3) @(negedge clk);
    #3;
    check("no_autostart", busy, 0);
`endif

    // zero-wait, known contents, throughput
    run(1, 0);

    // R before AR
    resp_mode = 1;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    run(0, 0);

    // SLVERR on word 2
    resp_mode = 0; err_at = 2;
    run(0, 0);
    err_at = -1;

    // backpressure on word 1 with err cleared by the new start
    resp_mode = 2; bp_mode = 2; bp_used = 0;
    run(0, 0);
    check("bp_applied", bp_used, 1);
    bp_mode = 0;

    // start while busy is ignored
    resp_mode = 0;
    run(0, 1);

    // randomized runs
    bp_mode = 1;
    for (int r = 0; r < 8; r++) begin
      resp_mode = $urandom_range(0, 2);
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WORDS - 1) : -1;
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      run(0, 0);
    end
    bp_mode = 0; err_at = -1; resp_mode = 0;

    // reset during REQ
    expect_run();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    #3;
    check("pre_rst_busy", busy, 1);
    rst_n = 0;
    #1;
    check_reset_values("midrst");
    exp_out.delete();
    exp_addr.delete();
    exp_done.delete();
`ifdef GFX_BOOT_FETCH_AUTOSTART_EN
    expect_run();
`endif
    repeat (2) @(negedge clk);
    rst_n = 1;
`ifdef GFX_BOOT_FETCH_AUTOSTART_EN
    @(negedge clk);
    #3;
    check("autostart_req", axi.arvalid, 1);
    wait_done("autostart2_timeout");
    drain_checks();
`else
    repeat (3) @(negedge clk);
    #3;
    check("post_rst_idle", busy, 0);
    check("post_rst_arvalid", axi.arvalid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
